wishbone_master_arbiter: RTL and testbench

- Two-master, one-slave Wishbone arbiter for the SOPC.
- Master 0 is the data-side bus interface; master 1 is the instruction-side bus interface. Both are Wishbone bus interface units with classic single-beat stb/cyc/ack.
- The block shares the single slave-side bus (interconnect or memory controller) between the two masters, holds the grant for the whole cyc period, and includes a watchdog that completes transfers the slave never acknowledges.

---
 rtl/wishbone_master_arbiter.sv | 154 +++++++++++++++
 tb/tb_wishbone_master_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_master_arbiter.sv
// ============================================================================
// wishbone_master_arbiter : two-master / one-slave classic Wishbone arbiter
// with a watchdog that force-completes unacknowledged transfers.  Rev 1.0
// ============================================================================
`default_nettype none

module wishbone_master_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_data_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  input  logic                m0_stb_i,
  input  logic                m0_cyc_i,
  output logic [DATA_W-1:0]   m0_data_o,
  output logic                m0_ack_o,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_data_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  input  logic                m1_stb_i,
  input  logic                m1_cyc_i,
  output logic [DATA_W-1:0]   m1_data_o,
  output logic                m1_ack_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_data_o,
  output logic                s_we_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  output logic                s_stb_o,
  output logic                s_cyc_o,
  input  logic [DATA_W-1:0]   s_data_i,
  input  logic                s_ack_i,
  output logic [1:0]          grant_o,
  output logic                timeout_o
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic            WD_EN    = (TIMEOUT > 0);
  localparam logic            RR_EN    = (ROUND_ROBIN != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2,
    ST_TOUT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;   // 0 = m0 last granted, 1 = m1
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             own;
  logic             stall;

  // Owner keeps the bus while its cyc is high; otherwise hand over directly.
  function automatic state_e release_next(input logic owner, input logic cyc0,
                                          input logic cyc1);
    state_e nxt;
    if (!owner) nxt = cyc0 ? ST_GNT0 : (cyc1 ? ST_GNT1 : ST_IDLE);
    else        nxt = cyc1 ? ST_GNT1 : (cyc0 ? ST_GNT0 : ST_IDLE);
    return nxt;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    own       = 1'b0;
    stall     = 1'b0;
    s_addr_o  = '0;
    s_data_o  = '0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_stb_o   = 1'b0;
    s_cyc_o   = 1'b0;
    m0_ack_o  = 1'b0;
    m0_data_o = '0;
    m1_ack_o  = 1'b0;
    m1_data_o = '0;
    grant_o   = 2'b00;
    timeout_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i)
          state_d = (RR_EN && !last_q) ? ST_GNT1 : ST_GNT0;
        else if (m0_cyc_i)
          state_d = ST_GNT0;
        else if (m1_cyc_i)
          state_d = ST_GNT1;
      end

      ST_GNT0, ST_GNT1: begin
        own      = (state_q == ST_GNT1);
        s_addr_o = own ? m1_addr_i : m0_addr_i;
        s_data_o = own ? m1_data_i : m0_data_i;
        s_we_o   = own ? m1_we_i   : m0_we_i;
        s_sel_o  = own ? m1_sel_i  : m0_sel_i;
        s_stb_o  = own ? m1_stb_i  : m0_stb_i;
        s_cyc_o  = own ? m1_cyc_i  : m0_cyc_i;
        grant_o  = own ? 2'b10 : 2'b01;
        if (own) begin
          m1_ack_o  = s_ack_i;
          m1_data_o = s_ack_i ? s_data_i : '0;
        end else begin
          m0_ack_o  = s_ack_i;
          m0_data_o = s_ack_i ? s_data_i : '0;
        end
        stall = s_stb_o & s_cyc_o & ~s_ack_i;
        // An ack in the same cycle as the final stall count wins over the watchdog.
        if (WD_EN && stall && (cnt_q == CNT_LAST))
          state_d = ST_TOUT;
        else
          state_d = release_next(own, m0_cyc_i, m1_cyc_i);
        if (WD_EN && (state_d == state_q) && !s_ack_i)
          cnt_d = cnt_q + CNT_W'(stall);
      end

      ST_TOUT: begin
        timeout_o = 1'b1;
        grant_o   = last_q ? 2'b10 : 2'b01;
        m0_ack_o  = ~last_q;
        m1_ack_o  = last_q;
        state_d   = release_next(last_q, m0_cyc_i, m1_cyc_i);
      end

      default: state_d = ST_IDLE;
    endcase

    last_d = last_q;
    if (state_d == ST_GNT0)      last_d = 1'b0;
    else if (state_d == ST_GNT1) last_d = 1'b1;
  end

endmodule

`default_nettype wire

// File: tb/tb_wishbone_master_arbiter.sv
// ============================================================================
// tb_wishbone_master_arbiter : directed bench for three arbiter configurations
// sharing one stimulus (RR/TIMEOUT=4, fixed-priority/TIMEOUT=4, RR/no watchdog).
// ============================================================================
`default_nettype none

module tb_wishbone_master_arbiter;

  localparam int RR = 0;  // ROUND_ROBIN=1, TIMEOUT=4
  localparam int FP = 1;  // ROUND_ROBIN=0, TIMEOUT=4
  localparam int NT = 2;  // ROUND_ROBIN=1, TIMEOUT=0

  logic        clk;
  logic        rst;
  logic [31:0] m0_addr, m0_wdat, m1_addr, m1_wdat, s_rdat;
  logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc, s_ack;
  logic [3:0]  m0_sel, m1_sel;

  logic [31:0] m0_data [3];
  logic [31:0] m1_data [3];
  logic [31:0] s_addr  [3];
  logic [31:0] s_data  [3];
  logic [3:0]  s_sel   [3];
  logic        m0_ack  [3];
  logic        m1_ack  [3];
  logic        s_we    [3];
  logic        s_stb   [3];
  logic        s_cyc   [3];
  logic        tout    [3];
  logic [1:0]  grant   [3];

  int n_chk  = 0;
  int n_pass = 0;
  logic bad;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wishbone_master_arbiter #(
      .ADDR_W(32), .DATA_W(32),
      .ROUND_ROBIN((g == FP) ? 0 : 1),
      .TIMEOUT((g == NT) ? 0 : 4)
    ) u_dut (
      .clk(clk), .rst(rst),
      .m0_addr_i(m0_addr), .m0_data_i(m0_wdat), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
      .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_data_o(m0_data[g]), .m0_ack_o(m0_ack[g]),
      .m1_addr_i(m1_addr), .m1_data_i(m1_wdat), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
      .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_data_o(m1_data[g]), .m1_ack_o(m1_ack[g]),
      .s_addr_o(s_addr[g]), .s_data_o(s_data[g]), .s_we_o(s_we[g]), .s_sel_o(s_sel[g]),
      .s_stb_o(s_stb[g]), .s_cyc_o(s_cyc[g]), .s_data_i(s_rdat), .s_ack_i(s_ack),
      .grant_o(grant[g]), .timeout_o(tout[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_m0(input logic cyc, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] sel);
    m0_cyc = cyc; m0_stb = cyc; m0_we = we; m0_addr = a; m0_wdat = d; m0_sel = sel;
  endtask

  task automatic set_m1(input logic cyc, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] sel);
    m1_cyc = cyc; m1_stb = cyc; m1_we = we; m1_addr = a; m1_wdat = d; m1_sel = sel;
  endtask

  task automatic do_reset();
    set_m0(1'b0, 1'b0, '0, '0, '0);
    set_m1(1'b0, 1'b0, '0, '0, '0);
    s_ack = 1'b0; s_rdat = '0;
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    // ---- single m0 read, ack in cycle 3
    do_reset();
    set_m0(1'b1, 1'b0, 32'h3000_0000, '0, 4'hF);
    smp();
    check("rst_grant", grant[RR], 2'b00);
    check("rst_scyc", s_cyc[RR], 1'b0);
    check("rst_tout", tout[RR], 1'b0);
    check("rst_sstb_c0", s_stb[RR], 1'b0);
    nxt();
    smp();
    check("t1_grant_c1", grant[RR], 2'b01);
    check("t1_sstb_c1", s_stb[RR], 1'b1);
    check("t1_saddr_c1", s_addr[RR], 32'h3000_0000);
    check("t1_m0ack_c1", m0_ack[RR], 1'b0);
    nxt();
    smp();
    check("t1_sstb_c2", s_stb[RR], 1'b1);
    nxt();
    s_ack = 1'b1; s_rdat = 32'h1234_5678;
    smp();
    check("t1_m0ack_c3", m0_ack[RR], 1'b1);
    check("t1_m0data_c3", m0_data[RR], 32'h1234_5678);
    check("t1_m1ack_c3", m1_ack[RR], 1'b0);
    check("t1_m1data_c3", m1_data[RR], 32'h0);
    nxt();
    s_ack = 1'b0;
    set_m0(1'b0, 1'b0, '0, '0, '0);
    smp();
    check("t1_m0ack_c4", m0_ack[RR], 1'b0);
    nxt();
    smp();
    check("t1_grant_c5", grant[RR], 2'b00);

    // ---- simultaneous requests, round robin
    do_reset();
    set_m0(1'b1, 1'b0, 32'h100, '0, 4'hF);
    set_m1(1'b1, 1'b0, 32'h200, '0, 4'hF);
    nxt();
    smp();
    check("t2_grant_c1", grant[RR], 2'b01);
    check("t2_saddr_c1", s_addr[RR], 32'h100);
    nxt();
    s_ack = 1'b1; s_rdat = 32'h11;
    smp();
    check("t2_m0ack", m0_ack[RR], 1'b1);
    check("t2_m0data", m0_data[RR], 32'h11);
    check("t2_m1ack_wait", m1_ack[RR], 1'b0);
    nxt();
    s_ack = 1'b0;
    set_m0(1'b0, 1'b0, '0, '0, '0);
    smp();
    check("t2_grant_c3", grant[RR], 2'b01);
    nxt();
    smp();
    check("t2_grant_c4", grant[RR], 2'b10);
    check("t2_saddr_c4", s_addr[RR], 32'h200);
    nxt();
    s_ack = 1'b1; s_rdat = 32'h22;
    smp();
    check("t2_m1ack", m1_ack[RR], 1'b1);
    check("t2_m1data", m1_data[RR], 32'h22);
    check("t2_m0ack_c5", m0_ack[RR], 1'b0);
    nxt();
    s_ack = 1'b0;
    set_m1(1'b0, 1'b0, '0, '0, '0);
    smp();
    check("t2_grant_c6", grant[RR], 2'b10);
    nxt();
    smp();
    check("t2_grant_c7", grant[RR], 2'b00);
    set_m0(1'b1, 1'b0, 32'h100, '0, 4'hF);
    set_m1(1'b1, 1'b0, 32'h200, '0, 4'hF);
    nxt();
    smp();
    check("t2_retie_grant", grant[RR], 2'b01);

    // ---- fixed priority, m1 write granted only while m0 idles
    do_reset();
    set_m0(1'b1, 1'b0, 32'h300, '0, 4'hF);
    set_m1(1'b1, 1'b1, 32'h400, 32'hDEAD_BEEF, 4'b1111);
    nxt();
    smp();
    check("t3_grant_c1", grant[FP], 2'b01);
    nxt();
    s_ack = 1'b1; s_rdat = 32'h33;
    smp();
    check("t3_m0ack_c2", m0_ack[FP], 1'b1);
    nxt();
    s_ack = 1'b0;
    set_m0(1'b0, 1'b0, '0, '0, '0);
    smp();
    check("t3_grant_c3", grant[FP], 2'b01);
    nxt();
    set_m0(1'b1, 1'b0, 32'h300, '0, 4'hF);
    s_ack = 1'b1; s_rdat = '0;
    smp();
    check("t3_grant_c4", grant[FP], 2'b10);
    check("t3_sdata", s_data[FP], 32'hDEAD_BEEF);
    check("t3_ssel", s_sel[FP], 4'b1111);
    check("t3_swe", s_we[FP], 1'b1);
    check("t3_saddr", s_addr[FP], 32'h400);
    check("t3_m1ack", m1_ack[FP], 1'b1);
    check("t3_m0ack_c4", m0_ack[FP], 1'b0);
    nxt();
    s_ack = 1'b0;
    set_m1(1'b0, 1'b0, '0, '0, '0);
    smp();
    check("t3_grant_c5", grant[FP], 2'b10);
    nxt();
    smp();
    check("t3_grant_c6", grant[FP], 2'b01);
    set_m0(1'b0, 1'b0, '0, '0, '0);
    nxt();
    smp();
    check("t3_grant_c7", grant[FP], 2'b00);
    set_m0(1'b1, 1'b0, 32'h300, '0, 4'hF);
    set_m1(1'b1, 1'b0, 32'h400, '0, 4'hF);
    nxt();
    smp();
    check("t3_fp_tie", grant[FP], 2'b01);
    check("t3_rr_tie", grant[RR], 2'b10);

    // ---- watchdog: stalled m1 read, then ack on the 4th stalled cycle
    do_reset();
    set_m1(1'b1, 1'b0, 32'h500, '0, 4'hF);
    for (int i = 0; i < 4; i++) nxt();
    smp();
    check("t4_tout_c4", tout[RR], 1'b0);
    check("t4_m1ack_c4", m1_ack[RR], 1'b0);
    check("t4_scyc_c4", s_cyc[RR], 1'b1);
    nxt();
    s_ack = 1'b1; s_rdat = 32'hAAAA_5555;
    smp();
    check("t4_tout_c5", tout[RR], 1'b1);
    check("t4_m1ack_c5", m1_ack[RR], 1'b1);
    check("t4_m1data_c5", m1_data[RR], 32'h0);
    check("t4_scyc_c5", s_cyc[RR], 1'b0);
    check("t4_sstb_c5", s_stb[RR], 1'b0);
    check("t4_grant_c5", grant[RR], 2'b10);
    nxt();
    s_ack = 1'b0;
    smp();
    check("t4_tout_c6", tout[RR], 1'b0);
    check("t4_grant_c6", grant[RR], 2'b10);
    check("t4_scyc_c6", s_cyc[RR], 1'b1);
    do_reset();
    set_m1(1'b1, 1'b0, 32'h500, '0, 4'hF);
    for (int i = 0; i < 4; i++) nxt();
    s_ack = 1'b1; s_rdat = 32'h55AA_55AA;
    smp();
    check("t4b_m1ack", m1_ack[RR], 1'b1);
    check("t4b_m1data", m1_data[RR], 32'h55AA_55AA);
    check("t4b_tout_c4", tout[RR], 1'b0);
    nxt();
    s_ack = 1'b0;
    smp();
    check("t4b_tout_c5", tout[RR], 1'b0);
    check("t4b_scyc_c5", s_cyc[RR], 1'b1);

    // ---- reset mid-transfer, then a fresh m1 request
    do_reset();
    set_m0(1'b1, 1'b0, 32'h600, '0, 4'hF);
    nxt();
    nxt();
    rst = 1'b1;
    smp();
    check("t5_grant_pre", grant[RR], 2'b01);
    nxt();
    rst = 1'b0;
    set_m0(1'b0, 1'b0, '0, '0, '0);
    set_m1(1'b1, 1'b0, 32'h700, '0, 4'hF);
    s_ack = 1'b1; s_rdat = 32'h77;
    smp();
    check("t5_grant_rst", grant[RR], 2'b00);
    check("t5_sstb_rst", s_stb[RR], 1'b0);
    check("t5_scyc_rst", s_cyc[RR], 1'b0);
    check("t5_saddr_rst", s_addr[RR], 32'h0);
    check("t5_m0ack_rst", m0_ack[RR], 1'b0);
    check("t5_m0data_rst", m0_data[RR], 32'h0);
    nxt();
    s_ack = 1'b0;
    smp();
    check("t5_m1_grant", grant[RR], 2'b10);
    check("t5_m1_saddr", s_addr[RR], 32'h700);

    // ---- no watchdog: 1000 stalled cycles then a single ack
    do_reset();
    set_m0(1'b1, 1'b0, 32'h800, '0, 4'hF);
    nxt();
    bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      smp();
      if (tout[NT] || m0_ack[NT] || grant[NT] != 2'b01) bad = 1'b1;
      nxt();
    end
    check("t6_no_tout", bad, 1'b0);
    s_ack = 1'b1; s_rdat = 32'h00C0_FFEE;
    smp();
    check("t6_m0ack", m0_ack[NT], 1'b1);
    check("t6_m0data", m0_data[NT], 32'h00C0_FFEE);
    check("t6_tout", tout[NT], 1'b0);
    nxt();
    s_ack = 1'b0;
    set_m0(1'b0, 1'b0, '0, '0, '0);
    smp();
    check("t6_m0ack_after", m0_ack[NT], 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
